// File: rtl/global_defs.sv
// rtl/global_defs.sv - shared MPU width constants
package global_defs;
    localparam int MATRIX_REG_SIZE = 4;
endpackage

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - MPU store-arbiter types and default parameters
package mpu_pkg;
    localparam int SARB_NREQ     = 2;
    localparam int SARB_START_TO = 4;

    typedef enum logic [2:0] {
        SARB_IDLE       = 3'd0,
        SARB_ISSUE      = 3'd1,
        SARB_WAIT_START = 3'd2,
        SARB_WAIT_DONE  = 3'd3,
        SARB_DONE       = 3'd4
    } store_arb_state_t;
endpackage

// File: rtl/mpu_rr_pick.sv
// rtl/mpu_rr_pick.sv - combinational round-robin picker starting after the last grant
module mpu_rr_pick #(
    parameter int NREQ  = 2,
    parameter int GBITS = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [GBITS-1:0] last_i,
    output logic [GBITS-1:0] grant_o,
    output logic             any_o
);
    logic [GBITS-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        any_o   = |req_i;
        for (int i = NREQ; i >= 1; i--) begin
            idx = GBITS'((int'(last_i) + i) % NREQ);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end
endmodule

// File: rtl/mpu_store_arb.sv
// rtl/mpu_store_arb.sv - round-robin arbiter/sequencer for the shared matrix store engine
module mpu_store_arb
    import mpu_pkg::*;
    import global_defs::*;
#(
    parameter int NREQ     = SARB_NREQ,
    parameter int START_TO = SARB_START_TO,
    parameter int GBITS    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid_in,
    input  logic [NREQ*MATRIX_REG_SIZE-1:0] req_addr_in,
    output logic [NREQ-1:0]              req_ready_out,
    output logic [NREQ-1:0]              req_done_out,
    output logic                         req_err_out,
    output logic                         store_en_out,
    output logic [MATRIX_REG_SIZE-1:0]   store_addr_out,
    input  logic                         store_busy_in,
    output logic [GBITS-1:0]             grant_id_out,
    output logic                         busy_out
);
    localparam int TBITS = (START_TO > 1) ? $clog2(START_TO) : 1;

    store_arb_state_t             state_q, state_d;
    logic [GBITS-1:0]             grant_q, grant_d;
    logic [GBITS-1:0]             last_q, last_d;
    logic [MATRIX_REG_SIZE-1:0]   addr_q, addr_d;
    logic [TBITS-1:0]             timer_q, timer_d;
    logic                         err_q, err_d;

    logic [GBITS-1:0]             pick_grant;
    logic                         pick_any;

    mpu_rr_pick #(
        .NREQ  (NREQ),
        .GBITS (GBITS)
    ) u_pick (
        .req_i   (req_valid_in),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        err_d   = err_q;
        unique case (state_q)
            SARB_IDLE: begin
                // Never hand out a start while the engine is still streaming a previous job.
                if (pick_any && !store_busy_in) begin
                    grant_d = pick_grant;
                    addr_d  = req_addr_in[pick_grant*MATRIX_REG_SIZE +: MATRIX_REG_SIZE];
                    state_d = SARB_ISSUE;
                end
            end
            SARB_ISSUE: begin
                timer_d = '0;
                state_d = SARB_WAIT_START;
            end
            SARB_WAIT_START: begin
                if (store_busy_in) begin
                    state_d = SARB_WAIT_DONE;
                end else if (timer_q == TBITS'(START_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = SARB_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SARB_WAIT_DONE: begin
                if (!store_busy_in) begin
                    state_d = SARB_DONE;
                end
            end
            SARB_DONE: begin
                last_d  = grant_q;
                err_d   = 1'b0;
                state_d = SARB_IDLE;
            end
            default: state_d = SARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SARB_IDLE;
            grant_q <= '0;
            last_q  <= GBITS'(NREQ - 1);
            addr_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign store_en_out   = (state_q == SARB_ISSUE);
    assign req_ready_out  = (state_q == SARB_ISSUE) ? (NREQ'(1) << grant_q) : '0;
    assign req_done_out   = (state_q == SARB_DONE) ? (NREQ'(1) << grant_q) : '0;
    assign req_err_out    = (state_q == SARB_DONE) && err_q;
    assign store_addr_out = addr_q;
    assign grant_id_out   = grant_q;
    assign busy_out       = (state_q != SARB_IDLE);
endmodule

// File: doc/mpu_store_arb.md
# mpu_store_arb

Round-robin arbiter and sequencer sharing the single matrix store engine (register file → memory) among NREQ requesters, such as the host command path and the multiply result writer. It accepts one store request at a time, issues a one-cycle start pulse and the matrix register address to the store engine, and tracks the engine's busy window to completion. It then returns a per-requester done pulse, or an error pulse if the engine never starts. It sits between the requesters and `mpu_store` in the MPU top level.

## Interface
- `NREQ`, 2: number of requesters; at least 1.
- `START_TO`, 4: cycles to wait in WAIT_START for engine busy before declaring an error; at least 1.
- `GBITS`, `(NREQ>1)?$clog2(NREQ):1`: derived width of the grant index.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_valid_in`, in, NREQ: per-requester store request; held until accepted or withdrawn.
- `req_addr_in`, in, NREQ*MATRIX_REG_SIZE: per-requester matrix register address; requester i occupies slice i.
- `req_ready_out`, out, NREQ: one-cycle accept pulse to the granted requester.
- `req_done_out`, out, NREQ: one-cycle completion pulse to the granted requester.
- `req_err_out`, out, 1: one-cycle pulse, coincident with `req_done_out`, on start timeout.
- `store_en_out`, out, 1: one-cycle start pulse to the store engine.
- `store_addr_out`, out, MATRIX_REG_SIZE: latched address; stable from ISSUE through DONE.
- `store_busy_in`, in, 1: store engine memory-enable, high while streaming.
- `grant_id_out`, out, GBITS: index of the current or most recent grant.
- `busy_out`, out, 1: high in every state except IDLE.

## Operation
- States (`store_arb_state_t`): SARB_IDLE, SARB_ISSUE, SARB_WAIT_START, SARB_WAIT_DONE, SARB_DONE.
- **IDLE**
  - Grant only when `|req_valid_in` and `store_busy_in==0`.
  - Pick the first valid requester searching from `last_grant+1`, wrapping modulo NREQ.
  - Latch the winner's address and index, then go to ISSUE.
  - If the engine is busy, hold in IDLE and grant nothing.
- **ISSUE** (exactly one cycle)
  - `store_en_out=1` and `req_ready_out[g]=1`; go to WAIT_START and clear the timer.
- **WAIT_START**
  - `store_busy_in==1` → WAIT_DONE.
  - Otherwise increment the timer; when it reaches START_TO-1 with busy still low → DONE with error flag set.
- **WAIT_DONE**
  - Stay while `store_busy_in==1`; on `store_busy_in==0` → DONE.
- **DONE** (one cycle)
  - `req_done_out[g]=1`; `req_err_out` = error flag.
  - Set `last_grant=g`, clear the error flag, go to IDLE.
- Handshake:
  - A requester holds valid and address stable until it sees ready.
  - It must drop valid or present a new request after ready.
  - Dropping valid before ready withdraws the request with no side effect.
  - `req_valid_in` is sampled only in IDLE.
- Outputs are registered or decoded from the state and latched registers only; no input→output combinational path.

## Timing
- Reset values:
  - state IDLE; `last_grant=NREQ-1`, so requester 0 wins the first tie.
  - timer 0; all outputs 0, including `store_addr_out`, `grant_id_out` and `busy_out`.
- Reset assertion mid-operation forces IDLE and zeroes outputs asynchronously. A pending done is lost and is not replayed; the store engine is reset by its own reset.
- Latency:
  - Valid sampled at edge E0 in IDLE → ISSUE during E0..E1 (ready, store_en, address, grant id all valid).
  - Busy falling seen at edge Ek → done pulse during Ek..Ek+1 → IDLE at Ek+1.
  - Minimum gap from a done pulse to the next `store_en_out`: 2 cycles.
- Timeout: with busy never rising, the done and error pulses occur START_TO+1 cycles after the ISSUE cycle.
- Wrap-around: with `last_grant=NREQ-1` the search starts at requester 0.
- NREQ=1 degenerates to a sequencer with `grant_id_out` fixed at 0.
- Requests arriving in any non-IDLE state wait; the arbiter never preempts.

## Structure
- In `mpu_pkg`: `store_arb_state_t` and default constants `SARB_NREQ` and `SARB_START_TO`.
- Width constants come from `global_defs` (`MATRIX_REG_SIZE`).
- One natural sub-module: `mpu_rr_pick`, a combinational round-robin priority picker.
  - Inputs: request vector, last grant.
  - Outputs: grant index, any-valid flag.

## Test plan
- Single request: requester 1 valid with address 3, engine busy 6 cycles → ready[1] and `store_en_out` in the same cycle; `store_addr_out=3` stable throughout; done[1] one cycle after busy falls; `req_err_out=0`.
- Contention (NREQ=2): both valid continuously → grants alternate 0,1,0,1; each requester gets ready once per grant; no overlapping `store_en_out` pulses.
- Start timeout: engine never raises busy → done pulse with `req_err_out=1` exactly 5 cycles after ISSUE (START_TO=4); next request is still granted normally.
- Engine busy in IDLE: `store_busy_in=1` while requester 0 is valid → no grant until busy drops; grant on the following edge.
- Withdrawal and reset: requester drops valid before grant → no ready, no store_en. Reset asserted during WAIT_DONE → all outputs 0 immediately, no done pulse; after release, requester 0 wins the first tie.
